// File: rtl/store_serializer.sv
// store_serializer: turns one 8/16/32-bit store request into a sequence of
// byte writes toward an 8-bit memory, with alignment checking.
module store_serializer #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ready,
  output logic        done,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEND  = 2'd1,
    DONE  = 2'd2,
    FAULT = 2'd3
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] data_reg, data_next;
  logic [1:0]  size_reg, size_next;
  logic [1:0]  beat_reg, beat_next;

  logic        req_bad;
  logic [1:0]  last_beat;
  logic [1:0]  byte_idx;
  logic [7:0]  data_bytes [4];

  // Split the latched store data into addressable byte lanes.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lanes
    assign data_bytes[gi] = data_reg[8*gi +: 8];
  end

  // Request is rejected when the size is illegal or the address is misaligned.
  always_comb begin
    req_bad = 1'b0;
    case (req_size)
      2'b00:   req_bad = 1'b0;
      2'b01:   req_bad = req_addr[0];
      2'b10:   req_bad = (req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  // Index of the final beat for the latched size (byte, halfword, word).
  always_comb begin
    last_beat = 2'd0;
    case (size_reg)
      2'b01:   last_beat = 2'd1;
      2'b10:   last_beat = 2'd3;
      default: last_beat = 2'd0;
    endcase
  end

  // Big-endian walks the lanes from the top of the stored quantity downward.
  always_comb begin
    byte_idx = beat_reg;
    if (BIG_ENDIAN) begin
      byte_idx = last_beat - beat_reg;
    end
  end

  // State and request registers; reset abandons any store in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= 32'd0;
      data_reg  <= 32'd0;
      size_reg  <= 2'd0;
      beat_reg  <= 2'd0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
      size_reg  <= size_next;
      beat_reg  <= beat_next;
    end
  end

  // Next-state logic: accept in IDLE, step beats in SEND, single-cycle DONE/FAULT.
  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    size_next  = size_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid) begin
          addr_next  = req_addr;
          data_next  = req_data;
          size_next  = req_size;
          beat_next  = 2'd0;
          state_next = req_bad ? FAULT : SEND;
        end
      end
      SEND: begin
        if (mem_ready) begin
          if (beat_reg == last_beat) begin
            state_next = DONE;
          end else begin
            beat_next = beat_reg + 2'd1;
          end
        end
      end
      DONE:    state_next = IDLE;
      FAULT:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; memory bus is driven to zero outside SEND.
  always_comb begin
    req_ready = (state_reg == IDLE);
    mem_we    = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 8'd0;
    done      = (state_reg == DONE);
    fault     = (state_reg == FAULT);
    if (state_reg == SEND) begin
      mem_we    = 1'b1;
      mem_addr  = addr_reg + {30'd0, beat_reg};
      mem_wdata = data_bytes[byte_idx];
    end
  end

endmodule

// File: tb/tb_store_serializer.sv
// Testbench for store_serializer: big- and little-endian instances driven in
// parallel from a vector table, with a byte-beat scoreboard per instance.
module tb_store_serializer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  size;
    int          stall;
    bit          exp_fault;
    int          exp_beats;
  } vector_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        mem_ready;

  logic        req_ready_o [2];
  logic        mem_we_o    [2];
  logic [31:0] mem_addr_o  [2];
  logic [7:0]  mem_wdata_o [2];
  logic        done_o      [2];
  logic        fault_o     [2];

  beat_t   sb0[$];
  beat_t   sb1[$];
  vector_t vecs [10];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  store_serializer #(.BIG_ENDIAN(1'b1)) dut_be (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_o[0]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_we(mem_we_o[0]), .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]),
    .mem_ready(mem_ready), .done(done_o[0]), .fault(fault_o[0])
  );

  store_serializer #(.BIG_ENDIAN(1'b0)) dut_le (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_o[1]),
    .req_addr(req_addr), .req_data(req_data), .req_size(req_size),
    .mem_we(mem_we_o[1]), .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]),
    .mem_ready(mem_ready), .done(done_o[1]), .fault(fault_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected beats: byte lanes listed LSB-first, BE instance reads them backwards.
  task automatic push_beats(input vector_t v);
    logic [7:0] b [4];
    b[0] = v.data[7:0];
    b[1] = v.data[15:8];
    b[2] = v.data[23:16];
    b[3] = v.data[31:24];
    for (int k = 0; k < v.exp_beats; k++) begin
      sb0.push_back('{addr: v.addr + k, data: b[v.exp_beats-1-k]});
      sb1.push_back('{addr: v.addr + k, data: b[k]});
    end
  endtask

  task automatic check_cycle(input int idx, input int i, input int c, input vector_t v,
                             input int exp_done, input int last);
    string pfx;
    bit    exp_we;
    beat_t e;
    int    qsz;
    pfx    = $sformatf("vec%0d dut%0d cyc%0d", idx, i, c);
    exp_we = !v.exp_fault && (c < exp_done);
    chk({pfx, " mem_we"}, mem_we_o[i], exp_we);
    chk({pfx, " done"}, done_o[i], !v.exp_fault && (c == exp_done));
    chk({pfx, " fault"}, fault_o[i], v.exp_fault && (c == 1));
    chk({pfx, " req_ready"}, req_ready_o[i], c == last);
    if (mem_we_o[i]) begin
      qsz = (i == 0) ? sb0.size() : sb1.size();
      chk({pfx, " beat_expected"}, (qsz > 0), 1);
      if (qsz > 0) begin
        e = (i == 0) ? sb0[0] : sb1[0];
        chk({pfx, " mem_addr"}, mem_addr_o[i], e.addr);
        chk({pfx, " mem_wdata"}, mem_wdata_o[i], e.data);
        if (mem_ready) begin
          if (i == 0) void'(sb0.pop_front());
          else        void'(sb1.pop_front());
        end
      end
    end else begin
      chk({pfx, " mem_addr_idle"}, mem_addr_o[i], 0);
      chk({pfx, " mem_wdata_idle"}, mem_wdata_o[i], 0);
    end
  endtask

  // Called just after a rising edge with the DUTs idle.
  task automatic run_vec(input int idx, input vector_t v);
    int exp_done;
    int last;
    exp_done = v.exp_fault ? 0 : v.exp_beats + 1 + v.stall;
    last     = v.exp_fault ? 2 : exp_done + 1;
    for (int i = 0; i < 2; i++) chk($sformatf("vec%0d dut%0d ready_before", idx, i), req_ready_o[i], 1);
    if (!v.exp_fault) push_beats(v);
    req_addr  = v.addr;
    req_data  = v.data;
    req_size  = v.size;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom);
    for (int c = 1; c <= last; c++) begin
      mem_ready = (c > v.stall);
      @(negedge clk);
      for (int i = 0; i < 2; i++) check_cycle(idx, i, c, v, exp_done, last);
      @(posedge clk);
      #1;
    end
    chk($sformatf("vec%0d scoreboard_empty", idx), sb0.size() + sb1.size(), 0);
    sb0.delete();
    sb1.delete();
    mem_ready = 1'b1;
  endtask

  initial begin
    vecs[0] = '{addr: 32'h0000_0100, data: 32'hAABB_CCDD, size: 2'b10, stall: 0, exp_fault: 0, exp_beats: 4};
    vecs[1] = '{addr: 32'h0000_0202, data: 32'h1234_5678, size: 2'b01, stall: 0, exp_fault: 0, exp_beats: 2};
    vecs[2] = '{addr: 32'h0000_0101, data: 32'hDEAD_BEEF, size: 2'b10, stall: 0, exp_fault: 1, exp_beats: 0};
    vecs[3] = '{addr: 32'h0000_0000, data: 32'h0BAD_F00D, size: 2'b11, stall: 0, exp_fault: 1, exp_beats: 0};
    vecs[4] = '{addr: 32'h0000_0007, data: 32'hFFFF_FF5A, size: 2'b00, stall: 3, exp_fault: 0, exp_beats: 1};
    vecs[5] = '{addr: 32'h0000_0203, data: 32'h1111_2222, size: 2'b01, stall: 0, exp_fault: 1, exp_beats: 0};
    vecs[6] = '{addr: 32'h0000_0102, data: 32'h3333_4444, size: 2'b10, stall: 0, exp_fault: 1, exp_beats: 0};
    vecs[7] = '{addr: 32'hFFFF_FFFC, data: 32'h0102_0304, size: 2'b10, stall: 1, exp_fault: 0, exp_beats: 4};
    vecs[8] = '{addr: 32'h0000_0003, data: 32'h9988_7766, size: 2'b00, stall: 0, exp_fault: 0, exp_beats: 1};
    vecs[9] = '{addr: 32'hFFFF_FFFE, data: 32'hCAFE_1234, size: 2'b01, stall: 2, exp_fault: 0, exp_beats: 2};

    reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = 32'd0;
    req_data  = 32'd0;
    req_size  = 2'd0;
    mem_ready = 1'b1;

    // Outputs during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset dut%0d req_ready", i), req_ready_o[i], 1);
      chk($sformatf("reset dut%0d mem_we", i), mem_we_o[i], 0);
      chk($sformatf("reset dut%0d mem_addr", i), mem_addr_o[i], 0);
      chk($sformatf("reset dut%0d mem_wdata", i), mem_wdata_o[i], 0);
      chk($sformatf("reset dut%0d done", i), done_o[i], 0);
      chk($sformatf("reset dut%0d fault", i), fault_o[i], 0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;

    for (int n = 0; n < 10; n++) begin
      run_vec(n, vecs[n]);
      $display("vector %0d addr=0x%08h size=%0d stall=%0d fault=%0d checked, failures so far %0d",
               n, vecs[n].addr, vecs[n].size, vecs[n].stall, vecs[n].exp_fault, n_fail);
    end

    // Reset in the middle of a word store, after two beats have gone out.
    req_addr  = 32'h0000_0300;
    req_data  = 32'hCAFE_BABE;
    req_size  = 2'b10;
    req_valid = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("midreset dut%0d mem_we", i), mem_we_o[i], 0);
      chk($sformatf("midreset dut%0d req_ready", i), req_ready_o[i], 1);
      chk($sformatf("midreset dut%0d done", i), done_o[i], 0);
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("midreset_after c%0d dut%0d done", c, i), done_o[i], 0);
        chk($sformatf("midreset_after c%0d dut%0d mem_we", c, i), mem_we_o[i], 0);
      end
    end
    $display("mid-store reset sequence checked, failures so far %0d", n_fail);

    // Request presented in the same edge as reset must be ignored.
    @(posedge clk);
    #1;
    reset     = 1'b1;
    req_addr  = 32'h0000_0400;
    req_data  = 32'h1357_9BDF;
    req_size  = 2'b10;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("reset_valid c%0d dut%0d mem_we", c, i), mem_we_o[i], 0);
        chk($sformatf("reset_valid c%0d dut%0d req_ready", c, i), req_ready_o[i], 1);
        chk($sformatf("reset_valid c%0d dut%0d fault", c, i), fault_o[i], 0);
      end
    end
    $display("reset-with-valid sequence checked, failures so far %0d", n_fail);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
